gt_sweep_driver: RTL
====================

// Module: gt_sweep_driver
// PURPOSE
//  Upstream stimulus/checker stage for the greater_than comparator.
//  It sweeps every {A,B} operand pair in ascending order and holds each pair for a fixed window.
//  At the end of each window it samples the comparator's F output and checks it against A>B.
//  It reports the count of true results, the mismatch count and the first failing index.
//  Replaces hand-written #delay sweeps with a clocked, self-checking sequencer.
// PARAMETERS
//  WIDTH        2   operand width of A and B; vectors N = 2**(2*WIDTH)
//  HOLD_CYCLES  20  cycles each vector is driven before F is sampled; legal range >= 2
// PORTS
//  clk            in   1          single clock, rising edge
//  rst            in   1          synchronous, active-high reset
//  start          in   1          begin a sweep; sampled only in IDLE
//  a_out          out  WIDTH      operand A to comparator
//  b_out          out  WIDTH      operand B to comparator
//  f_in           in   1          comparator result F
//  busy           out  1          sweep in progress
//  done           out  1          one-cycle pulse when the sweep completes
//  gt_count       out  2*WIDTH+1  number of vectors where f_in sampled 1
//  err_count      out  2*WIDTH+1  number of vectors where f_in != (A>B)
//  err_seen       out  1          at least one mismatch in the last sweep
//  first_err_idx  out  2*WIDTH    index {A,B} of the first mismatch; 0 if none
// BEHAVIOUR
//  Reset and clocking:
//  - Single clock domain. rst is synchronous and active-high and is checked at every edge.
//  - rst has priority over all other inputs.
//  - On reset: state=IDLE, and a_out, b_out, busy, done, gt_count, err_count, err_seen,
//    first_err_idx and idx are all 0.
//  States: IDLE -> DRIVE -> DONE -> IDLE.
//  IDLE:
//  - a_out = b_out = 0, busy = 0.
//  - The last sweep's results are held.
//  - If start=1 at edge k: clear the counters, err_seen and first_err_idx; set idx=0.
//    Go to DRIVE, with busy=1 and {a_out,b_out}=0 visible after edge k.
//  DRIVE:
//  - {a_out,b_out} = idx, where a_out holds the upper WIDTH bits.
//  - A hold counter counts 0..HOLD_CYCLES-1.
//  - At the edge where the hold counter is HOLD_CYCLES-1:
//    - sample f_in;
//    - gt_count += f_in;
//    - if f_in != (a_out > b_out), unsigned: err_count += 1 and err_seen = 1;
//      first_err_idx = idx only if err_seen was 0 before this edge.
//    - At that same edge: if idx == N-1, go to DONE; else idx += 1 and reset the hold counter.
//  - Each vector is therefore visible for exactly HOLD_CYCLES cycles.
//    There are no gap cycles between vectors.
//  DONE:
//  - done = 1 and busy = 0 for exactly one cycle, with a_out = b_out = 0. Then go to IDLE.
//  - Vector i is driven from edge k+i*HOLD_CYCLES; done is high after edge k+N*HOLD_CYCLES.
//  Arithmetic and boundary rules:
//  - Compare, gt_count and err_count are unsigned.
//  - The counter width 2*WIDTH+1 holds N without overflow, so no wrap is possible.
//  - idx stops at N-1 and never wraps into a second pass.
//  - start while busy, or in DONE, is ignored. No restart and no queuing.
//  - start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
//  - rst mid-sweep: everything returns to reset values at that edge.
//    Partial counts are discarded and done does not pulse.
//  - f_in is treated as combinationally valid within the hold window.
//    The block adds no synchroniser.
// TESTING (WIDTH=2, HOLD_CYCLES=20, N=16)
//  1. Ideal model, f_in=(A>B) -> done after 320 cycles from start edge;
//     gt_count=6, err_count=0, err_seen=0.
//  2. f_in stuck 0 -> gt_count=0, err_count=6, err_seen=1, first_err_idx=4 (A=1,B=0).
//  3. f_in stuck 1 -> gt_count=16, err_count=10, first_err_idx=0.
//  4. Faulty model f_in=(A>=B) -> gt_count=10, err_count=4, first_err_idx=0.
//  5. Start pulse at idx=3 while busy -> ignored; the sweep completes normally with test-1 results.
//     Then start again -> counters clear and the sweep repeats identically.
//  6. rst at idx=7 -> next cycle busy=0, all outputs 0, no done pulse.
//     A fresh start gives test-1 results after 320 cycles.

Source files
------------

// File: rtl/gt_sweep_driver.sv
// Clocked stimulus/checker for a greater_than comparator: sweeps every {A,B} pair,
// holds each for HOLD_CYCLES, and scores the sampled F against A>B.
module gt_sweep_driver #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               f_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   gt_count,
    output logic [2*WIDTH:0]   err_count,
    output logic               err_seen,
    output logic [2*WIDTH-1:0] first_err_idx
);

    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned CW = IW + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES);

    localparam logic [IW-1:0] LastIdx  = {IW{1'b1}};
    localparam logic [HW-1:0] LastHold = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   gt_count_q, gt_count_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic            err_seen_q, err_seen_d;
    logic [IW-1:0]   first_err_idx_q, first_err_idx_d;
    logic            expect_gt;

    assign expect_gt = idx_q[IW-1:WIDTH] > idx_q[WIDTH-1:0];

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        hold_d          = hold_q;
        gt_count_d      = gt_count_q;
        err_count_d     = err_count_q;
        err_seen_d      = err_seen_q;
        first_err_idx_d = first_err_idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d         = StDrive;
                    idx_d           = '0;
                    hold_d          = '0;
                    gt_count_d      = '0;
                    err_count_d     = '0;
                    err_seen_d      = 1'b0;
                    first_err_idx_d = '0;
                end
            end
            StDrive: begin
                if (hold_q == LastHold) begin
                    gt_count_d = gt_count_q + CW'(f_in);
                    if (f_in != expect_gt) begin
                        err_count_d = err_count_q + CW'(1);
                        err_seen_d  = 1'b1;
                        // Only the first mismatch of a sweep is recorded.
                        if (!err_seen_q) begin
                            first_err_idx_d = idx_q;
                        end
                    end
                    hold_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            hold_q          <= '0;
            gt_count_q      <= '0;
            err_count_q     <= '0;
            err_seen_q      <= 1'b0;
            first_err_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            hold_q          <= hold_d;
            gt_count_q      <= gt_count_d;
            err_count_q     <= err_count_d;
            err_seen_q      <= err_seen_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

    assign busy          = (state_q == StDrive);
    assign done          = (state_q == StDone);
    assign a_out         = busy ? idx_q[IW-1:WIDTH] : '0;
    assign b_out         = busy ? idx_q[WIDTH-1:0] : '0;
    assign gt_count      = gt_count_q;
    assign err_count     = err_count_q;
    assign err_seen      = err_seen_q;
    assign first_err_idx = first_err_idx_q;

endmodule
